// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared state type, widths and wrap-around helper for memory_arbiter
package mem_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} arb_state_t;

    localparam int MAX_CLIENTS = 16;
    localparam int IDX_W       = 4;
    localparam int N_W         = IDX_W + 1;
    localparam int TO_CNT_W    = 16;

    function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                     input logic [N_W-1:0]   n);
        return (N_W'(idx) == n - N_W'(1)) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// rtl/memory_arbiter_if.sv - request/grant bundle between memory clients and the arbiter
interface memory_arbiter_if #(parameter int CLIENTS = 4);
    localparam int OW = $clog2(CLIENTS);

    logic [CLIENTS-1:0] request;
    logic [CLIENTS-1:0] grant;
    logic [CLIENTS-1:0] timeout;
    logic [OW-1:0]      owner;
    logic               busy;

    modport master (output request, input grant, owner, busy, timeout);
    modport slave  (input request, output grant, owner, busy, timeout);
endinterface

// File: rtl/arbiter_rr_pick.sv
// rtl/arbiter_rr_pick.sv - combinational round-robin picker: first unmasked request at or above pointer
module arbiter_rr_pick
    import mem_arbiter_pkg::*;
#(
    parameter int CLIENTS = 4,
    localparam int OW = $clog2(CLIENTS)
) (
    input  logic [CLIENTS-1:0] request,
    input  logic [CLIENTS-1:0] mask,
    input  logic [OW-1:0]      pointer,
    output logic               found,
    output logic [OW-1:0]      index
);

    logic [OW-1:0] idx;

    always_comb begin
        found = 1'b0;
        index = '0;
        idx   = pointer;
        for (int i = 0; i < CLIENTS; i++) begin
            if (!found && request[idx] && !mask[idx]) begin
                found = 1'b1;
                index = idx;
            end
            idx = OW'(next_index(IDX_W'(idx), N_W'(CLIENTS)));
        end
    end

endmodule

// File: rtl/memory_arbiter.sv
// rtl/memory_arbiter.sv - round-robin owner of the shared memory bus with one-cycle turnaround
// Optional ownership limit with timeout pulse and client masking: MEM_ARBITER_TIMEOUT_EN
module memory_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int CLIENTS = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    memory_arbiter_if.slave   bus
);
    localparam int OW = $clog2(CLIENTS);

    if (CLIENTS < 2 || CLIENTS > MAX_CLIENTS || TIMEOUT < 1 || TIMEOUT >= 2**TO_CNT_W) begin : g_bad_cfg
        $error("memory_arbiter: CLIENTS or TIMEOUT out of range");
    end

    arb_state_t         state;
    logic [CLIENTS-1:0] grant_q;
    logic [OW-1:0]      owner_q;
    logic [OW-1:0]      pointer;
    logic               busy_q;
    logic               found;
    logic [OW-1:0]      pick_idx;
    logic [CLIENTS-1:0] mask;
    logic               expire;

    arbiter_rr_pick #(.CLIENTS(CLIENTS)) u_pick (
        .request (bus.request),
        .mask    (mask),
        .pointer (pointer),
        .found   (found),
        .index   (pick_idx)
    );

`ifdef MEM_ARBITER_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TIMEOUT - 1);

    logic [TO_CNT_W-1:0] cnt;
    logic [CLIENTS-1:0]  timeout_q;
    logic [CLIENTS-1:0]  owner_bit;

    assign owner_bit = CLIENTS'(1) << owner_q;
    // A request drop on the limit cycle wins: it is an ordinary release.
    assign expire    = (state == GRANT) && bus.request[owner_q] && (cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            mask      <= '0;
            timeout_q <= '0;
        end else begin
            timeout_q <= expire ? owner_bit : '0;
            mask      <= (mask & bus.request) | (expire ? owner_bit : '0);
            if (state == IDLE)
                cnt <= '0;
            else if (state == GRANT)
                cnt <= cnt + TO_CNT_W'(1);
        end
    end

    assign bus.timeout = timeout_q;
`else
    assign expire      = 1'b0;
    assign mask        = '0;
    assign bus.timeout = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            pointer <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        owner_q <= pick_idx;
                        grant_q <= CLIENTS'(1) << pick_idx;
                        busy_q  <= 1'b1;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (!bus.request[owner_q] || expire) begin
                        grant_q <= '0;
                        busy_q  <= 1'b0;
                        pointer <= OW'(next_index(IDX_W'(owner_q), N_W'(CLIENTS)));
                        state   <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant = grant_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Round-robin arbiter that shares the single tri-stated memory write/read bus among up to CLIENTS requesters, using the request/grant handshake of the arbiter client port. It sits beside the memory, one request/grant pair per client (memory writers, readers); exactly one client at a time drives the bus. A one-cycle turnaround gap follows every release so tri-state drivers never overlap.

## Interface
- CLIENTS, default 4: number of requesters, 2..16.
- TIMEOUT, default 255: maximum GRANT cycles per ownership. Used only with MEM_ARBITER_TIMEOUT_EN.
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  reset, synchronous and active-high.
- request  input  CLIENTS  per-client request; held high by the client until its transfer is done.
- grant  output  CLIENTS  per-client grant, registered, one-hot or zero.
- owner  output  $clog2(CLIENTS)  index of the current grantee; valid while busy=1.
- busy  output  1  high in GRANT state.
- timeout  output  CLIENTS  one-cycle pulse on the client whose grant was revoked. Tied to 0 without MEM_ARBITER_TIMEOUT_EN.

## Operation
- States: IDLE, GRANT, RELEASE.
- IDLE:
  - If any request bit is high, pick the first set bit searching upward from pointer, wrapping modulo CLIENTS.
  - Load owner and set grant[owner]; go to GRANT.
  - With no requests, stay in IDLE.
- GRANT:
  - grant[owner] is held high while request[owner]=1.
  - Requests from other clients are ignored; no preemption.
- GRANT -> RELEASE when request[owner]=0.
  - Clear grant.
  - Set pointer = owner+1, wrapping CLIENTS-1 -> 0.
- RELEASE lasts exactly one cycle with grant=0 (bus turnaround), then goes to IDLE.
- Fairness: a client that re-raises request one cycle after releasing, as a memory writer does between back-to-back words, is served only after every other pending client.
- Reset: grant=0, owner=0, busy=0, timeout=0, pointer=0, state IDLE.
  - Reset asserted mid-GRANT drops grant at that same edge.
- Request bits of clients other than owner may toggle freely; only their level in IDLE matters.

## Timing
- Request-to-grant latency: request high at edge n in IDLE -> grant high after edge n+1.
- Release-to-next-grant: request[owner] low at edge n -> grant 0 after n+1 (RELEASE) -> IDLE after n+2 -> next grant after n+3.
  - Minimum idle gap between owners: 2 cycles with grant all-zero.
- Single client continuously re-requesting: grant pattern 1,0,0,1 with one cycle of request low per transfer.
- owner is stable from the grant edge until the following IDLE.

## Configuration
- MEM_ARBITER_TIMEOUT_EN defined:
  - An 8..16-bit counter clears on entering GRANT and increments each GRANT cycle.
  - When the counter reaches TIMEOUT with request[owner] still 1, the arbiter:
    - clears grant;
    - pulses timeout[owner] for one cycle;
    - enters RELEASE;
    - advances pointer as for a normal release;
    - sets mask[owner].
  - A masked client is excluded from selection until its request goes low, which clears its mask bit.
  - Request drop and counter = TIMEOUT in the same cycle count as a normal release: no timeout pulse, no mask.
- MEM_ARBITER_TIMEOUT_EN undefined: no counter, no mask. Ownership is unbounded and timeout is constant 0.

## Structure
- Package mem_arbiter_pkg holds:
  - the state enum (IDLE, GRANT, RELEASE);
  - localparam widths;
  - function next_index(idx, n) for wrap-around.
- Sub-module arbiter_rr_pick: combinational round-robin picker.
  - Inputs: request, mask, pointer.
  - Outputs: found, index.
  - Instantiated once.
- The FSM, owner/pointer registers and timeout counter live in memory_arbiter.

## Test plan
- Reset, then request=4'b0101 at cycle 0:
  - grant=4'b0001 at cycle 1.
  - Drop request[0] at cycle 5 -> grant=0 at cycles 6-7, grant=4'b0100 at cycle 8.
- All four clients request continuously, each dropping request for 1 cycle after 3 granted cycles -> grant order 0,1,2,3,0; never two bits set; ≥2 zero cycles between owners.
- request[2] only, asserted at cycle 3 -> grant[2] at cycle 4; owner=2; busy=1.
- rst pulsed while grant=4'b0010 -> grant=0 after that edge; after release, a request on clients 1 and 3 selects client 1 (pointer=0).
- With MEM_ARBITER_TIMEOUT_EN, TIMEOUT=10, client 0 holds request forever, client 1 requesting:
  - timeout[0] pulses after 10 GRANT cycles;
  - grant moves to client 1 two cycles later;
  - client 0 gets no grant until it drops and re-raises request.
- With MEM_ARBITER_TIMEOUT_EN, request[owner] drops on the exact TIMEOUT cycle -> no timeout pulse; client not masked.
